// File: rtl/cla_sub_seq_pkg.sv
// Shared types and sizing helpers for the sequential CLA subtractor.
// Holds the FSM state type, default widths and slice-count arithmetic.
package cla_sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SLICE = 4;

    function automatic int unsigned num_slices(input int unsigned w, input int unsigned s);
        return w / s;
    endfunction

    // Slice index width; at least one bit even when there is a single slice.
    function automatic int unsigned idx_width(input int unsigned w, input int unsigned s);
        int unsigned n;
        n = w / s;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder: s = x + y + cin.
// Every carry is formed directly from generate/propagate terms and cin.
module cla_slice
    import cla_sub_seq_pkg::*;
#(
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             acc;
    logic             prod;

    assign g = x & y;
    assign p = x ^ y;

    // c[i] = OR_j ( g[j] & p[j+1..i-1] ) | ( p[0..i-1] & cin )
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        prod = 1'b0;
        c[0] = cin;
        for (int unsigned i = 1; i <= SLICE; i++) begin
            prod = cin;
            for (int unsigned k = 0; k < i; k++) begin
                prod = prod & p[k];
            end
            acc = prod;
            for (int unsigned j = 0; j < i; j++) begin
                prod = g[j];
                for (int unsigned k = j + 1; k < i; k++) begin
                    prod = prod & p[k];
                end
                acc = acc | prod;
            end
            c[i] = acc;
        end
    end

    assign s    = p ^ c[SLICE-1:0];
    assign cout = c[SLICE];

endmodule

// File: rtl/cla_sub_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one CLA slice per cycle, LSB first.
// Borrow travels between cycles as a registered (inverted) carry.
module cla_sub_seq
    import cla_sub_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             done
);

    localparam int unsigned N  = num_slices(WIDTH, SLICE);
    localparam int unsigned IW = idx_width(WIDTH, SLICE);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IW-1:0]    idx_r;

    logic [SLICE-1:0] sx;
    logic [SLICE-1:0] sy;
    logic [SLICE-1:0] ss;
    logic             scout;

    always_comb begin
        sx = a_r[idx_r*SLICE +: SLICE];
        sy = ~b_r[idx_r*SLICE +: SLICE];
    end

    cla_slice #(.SLICE(SLICE)) u_slice (
        .x    (sx),
        .y    (sy),
        .cin  (carry_r),
        .s    (ss),
        .cout (scout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && ready) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= ~bin;
                        idx_r   <= '0;
                        diff    <= '0;
                        bout    <= 1'b0;
                        ovf     <= 1'b0;
                        ready   <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    diff[idx_r*SLICE +: SLICE] <= ss;
                    carry_r <= scout;
                    idx_r   <= idx_r + IW'(1);
                    if (idx_r == LAST) begin
                        // Top slice's sum bit is the result MSB for the overflow test.
                        bout  <= ~scout;
                        ovf   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (ss[SLICE-1] != a_r[WIDTH-1]);
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
